// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// The FIFO, the interface and the top all import this package.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte handshake between the core (master) and the UART transmitter (slave).
// A byte moves on any rising edge where in_valid and in_ready are both high.
interface uart_tx_fifo_if;
    import uart_tx_pkg::*;

    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/uart_tx_fifo_byte_fifo.sv
// Synchronous byte FIFO with synchronous active-high reset.
// Pushes while full and pops while empty are ignored; rdata_o shows the head.
module byte_fifo
    import uart_tx_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_i,
    input  logic [DATA_BITS-1:0] wdata_i,
    input  logic                 pop_i,
    output logic [DATA_BITS-1:0] rdata_o,
    output logic [CW-1:0]        count_o,
    output logic                 full_o,
    output logic                 empty_o
);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q;
    logic [PW-1:0]        rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic [CW-1:0]        count_d;
    logic                 do_push;
    logic                 do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: the pointers and count decide what is live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a byte FIFO feeding a start/data/stop serializer.
// STOP chains straight into the next START when bytes are waiting, so bursts leave without gaps.
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_tx_fifo_if.slave                 bus,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS);

    tx_state_t            state_q;
    logic [BAUD_W-1:0]    baud_q;
    logic [BIT_W-1:0]     bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 tx_q;

    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 baud_done;

    // Ready looks only at the registered fill level, never at in_valid.
    assign bus.in_ready = !rst && !fifo_full;
    assign push         = bus.in_valid && bus.in_ready;
    assign baud_done    = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign pop          = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && baud_done));
    assign tx           = tx_q;
    assign busy         = (state_q != IDLE) || !fifo_empty;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (bus.in_data),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Serializer: tx is registered and always shows the level of the bit now in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= IDLE_LEVEL;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q   <= IDLE_LEVEL;
                    baud_q <= '0;
                    bit_q  <= '0;
                    if (pop) begin
                        shift_q <= fifo_rdata;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_q  <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (bit_q == BIT_W'(DATA_BITS - 1)) begin
                            bit_q   <= '0;
                            tx_q    <= IDLE_LEVEL;
                            state_q <= STOP;
                        end else begin
                            bit_q   <= bit_q + BIT_W'(1);
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (pop) begin
                            shift_q <= fifo_rdata;
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else begin
                            tx_q    <= IDLE_LEVEL;
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    tx_q    <= IDLE_LEVEL;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: a frame-level reference model predicts every output
// each cycle, and a UART receiver on tx checks decoded bytes against a scoreboard queue.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    uart_tx_fifo_if busIf ();

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (busIf),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: bytes waiting, cycles left in the current frame, byte on the wire.
    logic [7:0] mq[$];
    logic [7:0] expQ[$];
    int         rem     = 0;
    logic [7:0] cur     = 8'h00;
    bit         modelOn = 1'b0;
    bit         lastAcc = 1'b0;

    bit         rxActive = 1'b0;
    int         rxCnt    = 0;
    logic [7:0] rxByte   = 8'h00;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic expTx();
        int idx;
        if (rem == 0) return 1'b1;
        idx = (FRAME - rem) / CPB;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return cur[idx-1];
    endfunction

    // A frame lasts FRAME cycles; a new byte starts whenever the line is free or on its last cycle.
    always @(posedge clk) begin
        bit acc;
        bit popNow;
        if (rst) begin
            mq.delete();
            rem     = 0;
            modelOn = 1'b1;
            lastAcc = 1'b0;
        end else begin
            acc    = busIf.in_valid && (mq.size() < DEPTH);
            popNow = (mq.size() > 0) && (rem <= 1);
            if (popNow) begin
                cur = mq.pop_front();
                rem = FRAME;
            end else if (rem > 0) begin
                rem--;
            end
            if (acc) begin
                mq.push_back(busIf.in_data);
                expQ.push_back(busIf.in_data);
            end
            lastAcc = acc;
        end
    end

    always @(negedge clk) begin
        if (modelOn) begin
            checkOutput("tx", {31'd0, tx}, {31'd0, expTx()});
            checkOutput("busy", {31'd0, busy}, {31'd0, (rem > 0) || (mq.size() > 0)});
            checkOutput("fifo_count", {29'd0, fifo_count}, mq.size());
            checkOutput("in_ready", {31'd0, busIf.in_ready}, {31'd0, !rst && (mq.size() < DEPTH)});
        end
    end

    // Receiver: sample each bit mid-cell and compare the finished byte with the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            rxActive = 1'b0;
            expQ.delete();
        end else if (modelOn) begin
            if (!rxActive && tx === 1'b0) begin
                rxActive = 1'b1;
                rxCnt    = 0;
            end
            if (rxActive) begin
                if (rxCnt >= 6 && rxCnt <= 34 && (rxCnt % CPB) == 2) begin
                    rxByte[(rxCnt-6)/CPB] = tx;
                end
                if (rxCnt == 38) begin
                    checkOutput("stopBit", {31'd0, tx}, 32'd1);
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedFrame", {24'd0, rxByte}, 32'hFFFF_FFFF);
                    end else begin
                        checkOutput("rxByte", {24'd0, rxByte}, {24'd0, expQ.pop_front()});
                    end
                end
                if (rxCnt == FRAME - 1) rxActive = 1'b0;
                else rxCnt++;
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int n;
        busIf.in_data  = b;
        busIf.in_valid = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!lastAcc && n < 400);
        if (!lastAcc) checkOutput("acceptTimeout", 32'd0, 32'd1);
        if (gap > 0) begin
            busIf.in_valid = 1'b0;
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic waitIdle();
        int n;
        busIf.in_valid = 1'b0;
        n = 0;
        while ((mq.size() > 0 || rem > 0) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) checkOutput("idleTimeout", 32'd0, 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        busIf.in_data  = 8'h77;
        busIf.in_valid = 1'b1;
        rst            = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst            = 1'b0;
        busIf.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        $display("[TB] single byte");
        applyStimulus(8'hA5, 1);
        waitIdle();

        $display("[TB] back-to-back");
        applyStimulus(8'h00, 0);
        applyStimulus(8'hFF, 0);
        waitIdle();

        $display("[TB] overflow burst");
        for (int i = 0; i < 6; i++) applyStimulus(8'h11 + 8'(i), 0);
        waitIdle();

        $display("[TB] reset mid-frame");
        applyStimulus(8'h3C, 0);
        applyStimulus(8'h5A, 0);
        applyStimulus(8'hC3, 0);
        busIf.in_valid = 1'b0;
        n = 0;
        while (rem != 22 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) checkOutput("bit3Timeout", 32'd0, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (FRAME + 10) begin
            @(posedge clk);
            #1;
        end

        $display("[TB] wrap-around");
        for (int i = 1; i <= 9; i++) applyStimulus(8'(i), 0);
        waitIdle();

        $display("[TB] random traffic");
        for (int i = 0; i < 30; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 50)));
        end
        waitIdle();

        checkOutput("leftoverExpected", expQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter inside the `tt_um_acrypticcode` top-level. It is the output stage directly downstream of the project core logic. It accepts bytes from the core over a valid/ready handshake and queues them in a small synchronous FIFO. It serializes them as 8N1 frames on a single pin, which the top level routes to `uo_out[0]`.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 87: clock cycles per UART bit (10 MHz / 115200). Legal values are ≥1.
- `FIFO_DEPTH`, default 4: number of queued bytes. Must be a power of two, ≥2.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_data`  in  8  byte from the core.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  FIFO can accept a byte. Function of registered count only; never depends on `in_valid`.
- `tx`  out  1  serial line, registered, idle high.
- `busy`  out  1  High when the FSM is not in IDLE or the FIFO is non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of bytes queued, excluding the byte in the shifter.

## Operation
- Push: a byte is accepted on an edge where `in_valid && in_ready`.
- `in_ready` equals `fifo_count < FIFO_DEPTH` while `rst` is low, and is 0 while `rst` is high.
- When full, a push is refused even if a pop happens on the same edge. There is no pass-through.
- FIFO order is strict first-in, first-out. Pointers wrap modulo `FIFO_DEPTH`, and the extra count bit distinguishes full from empty.
- Simultaneous push and pop on a non-full, non-empty FIFO leaves `fifo_count` unchanged.
- Serializer FSM states are IDLE, START, DATA and STOP. A bit counter (0..7) and a baud counter (0..CLKS_PER_BIT-1) run alongside it.
- IDLE:
  - `tx`=1.
  - If the FIFO is non-empty: pop into the shift register, go to START, and set `tx`=0 on the same edge.
- START: hold `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
- DATA:
  - Send 8 bits LSB first, each for `CLKS_PER_BIT` cycles.
  - Shift right at each bit boundary.
  - After bit 7, go to STOP.
- STOP: `tx`=1 for `CLKS_PER_BIT` cycles. On the final edge of STOP:
  - If the FIFO is non-empty: pop and go directly to START, giving back-to-back frames with no idle gap.
  - Otherwise go to IDLE.
- A byte pushed into an empty FIFO is never popped on the same edge it is written.
- Reset, including mid-frame:
  - Next edge: FSM to IDLE, `tx`=1, counters 0, FIFO flushed.
  - Reset values: `tx`=1, `busy`=0, `fifo_count`=0, `in_ready`=0 while asserted.

## Timing
- Latency: accept on edge E0, then `fifo_count`=1 after E0. The FSM pops on E1, so `tx` falls after E1, 2 edges after acceptance.
- A frame is exactly 10×`CLKS_PER_BIT` cycles: 1 start, 8 data and 1 stop bit.
- `busy` falls on the final STOP edge when the FIFO is empty.
- With `CLKS_PER_BIT`=1, every bit lasts one cycle and the same rules hold.
- Throughput: one byte per 10×`CLKS_PER_BIT` cycles sustained. The FIFO absorbs bursts of up to `FIFO_DEPTH`+1 bytes, counting the byte in the shifter.

## Structure
- Package `uart_tx_pkg` holds:
  - `tx_state_t` enum: IDLE, START, DATA, STOP.
  - constant `DATA_BITS`=8.
  - constant `IDLE_LEVEL`=1'b1.
- Sub-module `byte_fifo`: synchronous FIFO parameterized by depth, with push/pop, `count`, `full` and `empty`, and synchronous active-high reset.
- The top holds the FSM, shift register and counters (about 200 lines total).

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- **Reset:** hold `rst` for 3 cycles with `in_valid`=1 → no byte accepted, `tx`=1, `busy`=0, `fifo_count`=0. `in_ready` goes to 1 in the first cycle after deassertion.
- **Single byte 0xA5:** `tx` falls 2 edges after accept, then follows 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles. `busy`=0 after 40 cycles of frame.
- **Back-to-back 0x00 then 0xFF:** 80 contiguous frame cycles with no idle cycle between the first STOP and the second START.
- **Overflow:** push 0x11–0x16 with `in_valid` held.
  - 0x11 goes to the shifter, then `fifo_count` reaches 4 holding 0x12–0x15, and `in_ready`=0.
  - 0x16 is accepted on the edge after 0x12 is popped.
  - `tx` emits 0x11..0x16 in order.
- **Reset mid-frame:** send 0x3C with 2 more queued, and assert `rst` during data bit 3 → `tx`=1 on the next edge and `fifo_count`=0. No further frame appears after release.
- **Wrap-around:** push 9 bytes 0x01–0x09 paced by `in_ready` → all 9 serialized in order with pointers wrapping twice.
